game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level Pong game controller: sequences the ball/paddle datapath through idle, serve, play, pause,
//  point and game-over phases. Owns both scores and the win decision. Drives the datapath run enable
//  and a one-cycle ball reset. Sits between the key inputs and the image generator; scores feed the score renderers.
// PARAMETERS
//  WIN_SCORE      7    score that ends the game; must be <= 2**SCORE_W-1
//  SCORE_W        3    score register width
//  SERVE_TICKS    60   ball_tick count spent in SERVE (auto-serve build only); >=1
//  POINT_TICKS    30   ball_tick count spent in POINT holdoff; >=1
//  OVER_TICKS     180  ball_tick count in GAME_OVER before auto-return to IDLE; >=1
// PORTS
//  CLOCK_25     in   1        system clock, 25 MHz
//  RESET_N      in   1        synchronous active-low reset
//  ball_tick    in   1        1-cycle enable at game-update rate; all timers count on it
//  start_key    in   1        start/serve key level, already synchronised
//  pause_key    in   1        pause key level, already synchronised
//  miss_p1      in   1        1-cycle pulse: ball passed player 1 (player 2 scores)
//  miss_p2      in   1        1-cycle pulse: ball passed player 2 (player 1 scores)
//  run_en       out  1        1 = datapath may move ball/paddles
//  ball_reset   out  1        1-cycle pulse: recentre ball, zero its velocity
//  serve_left   out  1        launch direction for next serve; 1 = toward player 1
//  score_1      out  SCORE_W  player 1 score
//  score_2      out  SCORE_W  player 2 score
//  winner       out  2        00 none, 01 player 1, 10 player 2
//  game_over    out  1        high throughout GAME_OVER
//  state_o      out  3        current state encoding, debug
// BEHAVIOUR
//  - Reset (RESET_N=0 at edge, any state): state IDLE, all outputs 0, scores 0, timer 0, key history 0.
//  - Key edges: start_rise/pause_rise = level & ~registered previous level; one cycle each.
//  - IDLE (0): run_en=0. start_rise -> SERVE; scores and winner cleared, ball_reset pulsed same edge.
//  - SERVE (1): run_en=0. Timer loaded SERVE_TICKS on entry, decrements on ball_tick.
//  - PLAY (2): run_en=1. Miss priority over pause in the same cycle; pause_rise dropped.
//     miss_p1 only: score_2+1, serve_left=1. miss_p2 only: score_1+1, serve_left=0.
//     Both same cycle: void rally, no score change, serve_left toggles.
//     After increment, new score == WIN_SCORE -> GAME_OVER, winner set; else -> POINT.
//     pause_rise (no miss) -> PAUSE.
//  - PAUSE (3): run_en=0, all datapath state frozen. pause_rise -> PLAY. Miss pulses ignored.
//  - POINT (4): run_en=0. ball_reset pulses on the entry edge. After POINT_TICKS ticks -> SERVE.
//  - GAME_OVER (5): run_en=0, game_over=1; scores and winner held.
//     start_rise -> SERVE with scores cleared and ball_reset pulse.
//     OVER_TICKS ticks elapsed -> IDLE; scores held until next start.
//  - miss_p1/miss_p2 ignored in every state except PLAY.
//  - Arithmetic: score increment never wraps; WIN_SCORE reached first. Timer width $clog2(max ticks+1).
//    Timer transitions fire on the ball_tick where the timer is 1.
//  - All outputs registered; state change visible the cycle after the causing input.
// CONFIGURATION
//  PONG_AUTO_SERVE_EN defined:
//    SERVE -> PLAY when SERVE_TICKS ticks elapse. start_rise in SERVE is ignored.
//  Not defined:
//    SERVE -> PLAY only on start_rise. Timer is unused in SERVE and SERVE_TICKS is ignored.
// STRUCTURE
//  - State encodings (IDLE..GAME_OVER) and default WIN_SCORE go in the shared global_symbols.vh header.
//  - One sub-module: game_tick_timer. Loadable down-counter; load/value/ball_tick in; expire pulse out.
//  - Instanced once; loaded on every state entry.
// TESTING
//  1. Reset, start_key rise -> SERVE, ball_reset=1 one cycle, scores 0. Auto build: 60 ticks -> PLAY, run_en=1.
//  2. PLAY, miss_p1 pulse -> score_2=1, serve_left=1, POINT, ball_reset pulse, run_en=0. 30 ticks -> SERVE.
//  3. score_1=6, miss_p2 -> score_1=7, winner=01, game_over=1. 180 ticks -> IDLE, scores still 7/x.
//  4. PLAY, miss_p1 and miss_p2 same cycle -> scores unchanged, serve_left toggled, POINT.
//  5. PLAY, pause rise -> PAUSE run_en=0; miss_p1 ignored; second pause rise -> PLAY, scores unchanged.
//  6. RESET_N low mid-POINT with timer=12 -> next cycle IDLE, all outputs 0; non-auto build: SERVE holds until start rise.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared state encodings, default win score and sizing helper for the Pong game sequencer.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam int unsigned WIN_SCORE_DEFAULT = 7;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_sequencer_timer.sv
// game_tick_timer: loadable down-counter stepped by ball_tick; expire is high on the tick where it reaches 1.
module game_tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         ball_tick,
  output logic         expire
);

  logic [W-1:0] count;

  // A tick coinciding with load is counted, so a load issued the cycle after a
  // state entry behaves as if the count had been loaded on the entry edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (ball_tick && value != '0) ? value - W'(1) : value;
    end else if (ball_tick && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = ball_tick && (load ? (value == W'(1)) : (count == W'(1)));

endmodule

// File: rtl/game_sequencer.sv
// Pong game controller: idle/serve/play/pause/point/game-over sequencing, scores and win decision.
// Build option: define PONG_AUTO_SERVE_EN to serve automatically after SERVE_TICKS ball ticks.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEFAULT,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned POINT_TICKS = 30,
  parameter int unsigned OVER_TICKS  = 180
) (
  input  logic               CLOCK_25,
  input  logic               RESET_N,
  input  logic               ball_tick,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic               miss_p1,
  input  logic               miss_p2,
  output logic               run_en,
  output logic               ball_reset,
  output logic               serve_left,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [1:0]         winner,
  output logic               game_over,
  output logic [2:0]         state_o
);

  localparam int unsigned TW = $clog2(max3(SERVE_TICKS, POINT_TICKS, OVER_TICKS) + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t            state;
  logic              start_prev, pause_prev;
  logic              start_rise, pause_rise;
  logic              tmr_load, expire;
  logic [TW-1:0]     tmr_value;
  logic [SCORE_W-1:0] inc_1, inc_2;

  assign start_rise = start_key & ~start_prev;
  assign pause_rise = pause_key & ~pause_prev;
  assign inc_1      = score_1 + SCORE_W'(1);
  assign inc_2      = score_2 + SCORE_W'(1);
  assign state_o    = state;

  game_tick_timer #(.W(TW)) u_timer (
    .clk       (CLOCK_25),
    .rst_n     (RESET_N),
    .load      (tmr_load),
    .value     (tmr_value),
    .ball_tick (ball_tick),
    .expire    (expire)
  );

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      tmr_load   <= 1'b0;
      tmr_value  <= '0;
      run_en     <= 1'b0;
      ball_reset <= 1'b0;
      serve_left <= 1'b0;
      score_1    <= '0;
      score_2    <= '0;
      winner     <= 2'b00;
      game_over  <= 1'b0;
    end else begin
      start_prev <= start_key;
      pause_prev <= pause_key;
      ball_reset <= 1'b0;
      tmr_load   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state      <= ST_SERVE;
            score_1    <= '0;
            score_2    <= '0;
            winner     <= 2'b00;
            ball_reset <= 1'b1;
            tmr_load   <= 1'b1;
            tmr_value  <= TW'(SERVE_TICKS);
          end
        end
        ST_SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
          if (expire) begin
`else
          if (start_rise) begin
`endif
            state     <= ST_PLAY;
            run_en    <= 1'b1;
            tmr_load  <= 1'b1;
            tmr_value <= '0;
          end
        end
        ST_PLAY: begin
          if (miss_p1 || miss_p2) begin
            run_en    <= 1'b0;
            state     <= ST_POINT;
            tmr_load  <= 1'b1;
            tmr_value <= TW'(POINT_TICKS);
            if (miss_p1 && miss_p2) begin
              serve_left <= ~serve_left;
              ball_reset <= 1'b1;
            end else if (miss_p1) begin
              score_2    <= inc_2;
              serve_left <= 1'b1;
              if (inc_2 == WIN) begin
                state     <= ST_GAME_OVER;
                winner    <= 2'b10;
                game_over <= 1'b1;
                tmr_value <= TW'(OVER_TICKS);
              end else begin
                ball_reset <= 1'b1;
              end
            end else begin
              score_1    <= inc_1;
              serve_left <= 1'b0;
              if (inc_1 == WIN) begin
                state     <= ST_GAME_OVER;
                winner    <= 2'b01;
                game_over <= 1'b1;
                tmr_value <= TW'(OVER_TICKS);
              end else begin
                ball_reset <= 1'b1;
              end
            end
          end else if (pause_rise) begin
            state     <= ST_PAUSE;
            run_en    <= 1'b0;
            tmr_load  <= 1'b1;
            tmr_value <= '0;
          end
        end
        ST_PAUSE: begin
          if (pause_rise) begin
            state     <= ST_PLAY;
            run_en    <= 1'b1;
            tmr_load  <= 1'b1;
            tmr_value <= '0;
          end
        end
        ST_POINT: begin
          if (expire) begin
            state     <= ST_SERVE;
            tmr_load  <= 1'b1;
            tmr_value <= TW'(SERVE_TICKS);
          end
        end
        ST_GAME_OVER: begin
          if (start_rise) begin
            state      <= ST_SERVE;
            score_1    <= '0;
            score_2    <= '0;
            winner     <= 2'b00;
            game_over  <= 1'b0;
            ball_reset <= 1'b1;
            tmr_load   <= 1'b1;
            tmr_value  <= TW'(SERVE_TICKS);
          end else if (expire) begin
            state     <= ST_IDLE;
            game_over <= 1'b0;
            tmr_load  <= 1'b1;
            tmr_value <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          run_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected output snapshots, a negedge monitor compares them.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ball_tick = 1'b0, start_key = 1'b0, pause_key = 1'b0;
  logic       miss_p1 = 1'b0, miss_p2 = 1'b0;
  logic       run_en, ball_reset, serve_left, game_over;
  logic [2:0] score_1, score_2, state_o;
  logic [1:0] winner;

  typedef struct packed {
    logic [2:0] st;
    logic       run_en;
    logic       ball_reset;
    logic       serve_left;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [1:0] winner;
    logic       game_over;
  } snap_t;

  snap_t cur;
  snap_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  game_sequencer #(
    .WIN_SCORE(7), .SCORE_W(3), .SERVE_TICKS(60), .POINT_TICKS(30), .OVER_TICKS(180)
  ) dut (
    .CLOCK_25(clk), .RESET_N(rst_n), .ball_tick(ball_tick), .start_key(start_key),
    .pause_key(pause_key), .miss_p1(miss_p1), .miss_p2(miss_p2), .run_en(run_en),
    .ball_reset(ball_reset), .serve_left(serve_left), .score_1(score_1), .score_2(score_2),
    .winner(winner), .game_over(game_over), .state_o(state_o)
  );

  always #20 clk = ~clk;

  // Monitor: compares every queued expectation against the DUT outputs away from the edge.
  always @(negedge clk) begin
    snap_t act, e;
    string n;
    act = '{state_o, run_en, ball_reset, serve_left, score_1, score_2, winner, game_over};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: actual st=%0d run=%b brst=%b sl=%b s1=%0d s2=%0d win=%b go=%b expected st=%0d run=%b brst=%b sl=%b s1=%0d s2=%0d win=%b go=%b",
                 n, act.st, act.run_en, act.ball_reset, act.serve_left, act.s1, act.s2, act.winner,
                 act.game_over, e.st, e.run_en, e.ball_reset, e.serve_left, e.s1, e.s2, e.winner,
                 e.game_over);
      end
    end
  end

  task automatic step(input string name);
    @(posedge clk);
    #1;
    ball_tick = 1'b0;
    miss_p1   = 1'b0;
    miss_p2   = 1'b0;
    exp_q.push_back(cur);
    name_q.push_back(name);
  endtask

  task automatic tick(input string name);
    ball_tick = 1'b1;
    step(name);
  endtask

  task automatic serve_to_play();
`ifdef PONG_AUTO_SERVE_EN
    repeat (59) tick("serve_wait");
    cur.st = 3'd2; cur.run_en = 1'b1;
    tick("auto_serve_play");
`else
    repeat (3) tick("serve_hold");
    start_key = 1'b1;
    cur.st = 3'd2; cur.run_en = 1'b1;
    step("start_serve_play");
    start_key = 1'b0;
`endif
  endtask

  task automatic point_to_serve();
    repeat (29) tick("point_wait");
    cur.st = 3'd1;
    tick("point_to_serve");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '0;
    step("reset");
    step("reset_hold");
    rst_n = 1'b1;
    miss_p1 = 1'b1;
    step("idle_miss_ignored");

    // Start from IDLE
    start_key = 1'b1;
    cur.st = 3'd1; cur.ball_reset = 1'b1;
    step("start_to_serve");
    start_key = 1'b0;
    cur.ball_reset = 1'b0;
    step("serve_brst_drop");
    serve_to_play();

    // miss_p1: player 2 scores
    miss_p1 = 1'b1;
    cur.st = 3'd4; cur.run_en = 1'b0; cur.ball_reset = 1'b1; cur.s2 = 3'd1; cur.serve_left = 1'b1;
    step("miss_p1_point");
    cur.ball_reset = 1'b0;
    point_to_serve();
    serve_to_play();

    // both misses void the rally
    miss_p1 = 1'b1; miss_p2 = 1'b1;
    cur.st = 3'd4; cur.run_en = 1'b0; cur.ball_reset = 1'b1; cur.serve_left = 1'b0;
    step("both_miss_void");
    cur.ball_reset = 1'b0;
    point_to_serve();
    serve_to_play();

    // pause / resume with ignored miss
    pause_key = 1'b1;
    cur.st = 3'd3; cur.run_en = 1'b0;
    step("pause_enter");
    step("pause_level_held");
    pause_key = 1'b0;
    miss_p1 = 1'b1;
    step("pause_miss_ignored");
    pause_key = 1'b1;
    cur.st = 3'd2; cur.run_en = 1'b1;
    step("pause_exit");
    pause_key = 1'b0;
    step("play_resumed");

    // player 1 climbs to 6
    for (int i = 1; i <= 6; i++) begin
      miss_p2 = 1'b1;
      cur.st = 3'd4; cur.run_en = 1'b0; cur.ball_reset = 1'b1; cur.s1 = 3'(i); cur.serve_left = 1'b0;
      step("miss_p2_point");
      cur.ball_reset = 1'b0;
      point_to_serve();
      serve_to_play();
    end

    // winning point
    miss_p2 = 1'b1;
    cur.st = 3'd5; cur.run_en = 1'b0; cur.s1 = 3'd7; cur.winner = 2'b01; cur.game_over = 1'b1;
    step("win_p1");
    for (int i = 0; i < 179; i++) begin
      if (i == 10) miss_p1 = 1'b1;
      tick("over_wait");
    end
    cur.st = 3'd0; cur.game_over = 1'b0;
    tick("over_to_idle");
    step("idle_scores_held");

    // restart clears scores, then reset mid-POINT
    start_key = 1'b1;
    cur.st = 3'd1; cur.ball_reset = 1'b1; cur.s1 = 3'd0; cur.s2 = 3'd0; cur.winner = 2'b00;
    step("restart_clears");
    start_key = 1'b0;
    cur.ball_reset = 1'b0;
    step("restart_serve");
    serve_to_play();
    miss_p1 = 1'b1;
    cur.st = 3'd4; cur.run_en = 1'b0; cur.ball_reset = 1'b1; cur.s2 = 3'd1; cur.serve_left = 1'b1;
    step("miss_before_reset");
    cur.ball_reset = 1'b0;
    repeat (18) tick("point_partial");
    rst_n = 1'b0;
    cur = '0;
    step("reset_mid_point");
    rst_n = 1'b1;
    repeat (3) tick("idle_after_reset");
    start_key = 1'b1;
    cur.st = 3'd1; cur.ball_reset = 1'b1;
    step("start_after_reset");
    start_key = 1'b0;
    cur.ball_reset = 1'b0;
    serve_to_play();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
